// File: rtl/signed_divider.sv
// Sequential signed restoring divider: 10-bit dividend / 6-bit divisor, one quotient bit per clock.
// Optional divide-by-zero fast path enabled by defining DIVIDER_DBZ_EN.
module signed_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] x_in,
  input  logic [5:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [9:0] quotient,
  output logic [5:0] remainder,
  output logic       dbz,
  output logic       ovf
);
  localparam int unsigned DW = 10;
  localparam int unsigned VW = 6;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW:0]   dvs_q, dvs_d;
  logic          xs_q, xs_d;
  logic          ys_q, ys_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] x_mag;
  logic [VW:0]   y_ext, y_mag;
  logic [VW:0]   rem_sh;
  logic [VW+1:0] trial;
  logic          trial_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    x_mag    = x_in[DW-1] ? (~x_in + DW'(1)) : x_in;
    y_ext    = {y_in[VW-1], y_in};
    y_mag    = y_in[VW-1] ? (~y_ext + (VW+1)'(1)) : y_ext;
    // Dividend bits shift out of quo_q into the partial remainder; quotient bits shift in.
    rem_sh   = {rem_q, quo_q[DW-1]};
    trial    = {1'b0, rem_sh} - {1'b0, dvs_q};
    trial_ok = ~trial[VW+1];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          xs_d    = x_in[DW-1];
          ys_d    = y_in[VW-1];
          quo_d   = x_mag;
          dvs_d   = y_mag;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ITER;
`ifdef DIVIDER_DBZ_EN
          if (y_in == '0) begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            dbz_d       = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
            state_d     = DONE;
          end
`endif
        end
      end
      ITER: begin
        rem_d = VW'(trial_ok ? trial : {1'b0, rem_sh});
        quo_d = {quo_q[DW-2:0], trial_ok};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = (xs_q ^ ys_q) ? (~quo_q + DW'(1)) : quo_q;
        remainder_d = xs_q ? (~rem_q + VW'(1)) : rem_q;
        // Only a positive quotient of magnitude 512 (-512 / -1) is unrepresentable.
        ovf_d       = ~(xs_q ^ ys_q) & quo_q[DW-1];
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
endmodule
